// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  // Frame start marker.
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Frame field widths: 16-bit word count, 32-bit instruction words.
  localparam int LEN_W  = 16;
  localparam int WORD_W = 32;

  // Loader frame-parsing states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/imem_loader_packer.sv
// Packs a stream of bytes into big-endian 32-bit words. The word and its
// valid pulse are presented combinationally with the 4th byte so the parent
// can register them straight into the memory write port.
module imem_loader_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              srst,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]  cnt_reg;
  // Only the first three bytes of a word need storing; the 4th is live.
  logic [23:0] shift_reg;

  assign word_valid = byte_valid && (cnt_reg == 2'd3);
  assign word       = {shift_reg, byte_data};

  // Byte counter and shift register; first byte ends up in word[31:24].
  always_ff @(posedge clk) begin
    if (srst || clr) begin
      cnt_reg   <= 2'd0;
      shift_reg <= 24'd0;
    end else if (byte_valid) begin
      cnt_reg   <= cnt_reg + 2'd1;
      shift_reg <= {shift_reg[15:0], byte_data};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Runtime instruction-memory loader: parses a framed byte stream, writes the
// packed words to the instruction memory and holds the core in reset until a
// complete image with a matching XOR checksum has been received.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         IMEM_AW   = 10,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               im_we,
  output logic [IMEM_AW-1:0] im_addr,
  output logic [WORD_W-1:0]  im_wdata,
  output logic               cpu_rst,
  output logic               done,
  output logic               err
);

  localparam int unsigned MAX_WORDS = 32'd1 << IMEM_AW;

  state_t             state_reg, state_next;
  logic [7:0]         len_hi_reg;
  logic [LEN_W-1:0]   words_left_reg;
  logic [IMEM_AW-1:0] addr_reg;
  logic [7:0]         csum_reg;

  logic               xfer;
  logic               sync_start;
  logic [LEN_W-1:0]   len_n;
  logic               pack_valid;
  logic               word_valid;
  logic [WORD_W-1:0]  word;

  assign xfer       = rx_valid && rx_ready;
  assign len_n      = {len_hi_reg, rx_data};
  assign pack_valid = xfer && (state_reg == ST_DATA);

  // Status is a pure function of the registered state, so done and cpu_rst
  // flip on the same edge.
  assign done    = (state_reg == ST_DONE);
  assign err     = (state_reg == ST_ERR);
  assign cpu_rst = (state_reg != ST_DONE);

  imem_loader_packer u_packer (
    .clk        (clk),
    .srst       (rst),
    .clr        (sync_start),
    .byte_valid (pack_valid),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; a sync byte only starts a frame outside an active frame.
  always_comb begin
    state_next = state_reg;
    sync_start = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (xfer && (rx_data == SYNC_BYTE)) begin
          sync_start = 1'b1;
          state_next = ST_LEN_HI;
        end
      end
      ST_LEN_HI: if (xfer) state_next = ST_LEN_LO;
      ST_LEN_LO: begin
        if (xfer) begin
          if ({16'd0, len_n} > MAX_WORDS) state_next = ST_ERR;
          else if (len_n == '0)           state_next = ST_CSUM;
          else                            state_next = ST_DATA;
        end
      end
      ST_DATA: if (word_valid && (words_left_reg == 16'd1)) state_next = ST_CSUM;
      ST_CSUM: begin
        if (xfer) state_next = (csum_reg == rx_data) ? ST_DONE : ST_ERR;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: ready flag, length/address counters, checksum and write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ready       <= 1'b0;
      im_we          <= 1'b0;
      im_addr        <= '0;
      im_wdata       <= '0;
      len_hi_reg     <= 8'd0;
      words_left_reg <= '0;
      addr_reg       <= '0;
      csum_reg       <= 8'd0;
    end else begin
      rx_ready <= 1'b1;
      im_we    <= word_valid;
      if (sync_start) begin
        addr_reg <= '0;
        im_addr  <= '0;
        csum_reg <= 8'd0;
      end
      if (xfer && (state_reg == ST_LEN_HI || state_reg == ST_LEN_LO ||
                   state_reg == ST_DATA)) begin
        csum_reg <= csum_reg ^ rx_data;
      end
      if (xfer && state_reg == ST_LEN_HI) len_hi_reg <= rx_data;
      if (xfer && state_reg == ST_LEN_LO) words_left_reg <= len_n;
      if (word_valid) begin
        im_addr        <= addr_reg;
        im_wdata       <= word;
        addr_reg       <= addr_reg + 1'b1;
        words_left_reg <= words_left_reg - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: reset, nominal load, restart, bad
// checksum, oversize/empty length, noise, gaps and mid-frame reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [7:0]  fr[$];
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] ea[$];
  logic [31:0] ed[$];

  imem_loader #(.IMEM_AW(10), .SYNC_BYTE(8'hA5)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Capture every write strobe mid-cycle; a strobe longer than one cycle
  // shows up as an extra entry.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wa.push_back({22'd0, im_addr});
      wd.push_back(im_wdata);
      $display("write addr=%0d data=%h", im_addr, im_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_writes(input string tag);
    chk({tag, "_count"}, wa.size(), ea.size());
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wa[i], ea[i]);
      chk($sformatf("%s_data%0d", tag, i), wd[i], ed[i]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Sends the bytes in fr, with 0..gap_max idle cycles after each one.
  task automatic send_frame(input int gap_max);
    foreach (fr[i]) begin
      send_byte(fr[i]);
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic expect_nominal_writes();
    ea = '{32'd0, 32'd1};
    ed = '{32'h20080005, 32'h01095020};
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Reset state
    @(posedge clk); #1;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_cpu_rst",  cpu_rst, 1);
    chk("rst_done",     done, 0);
    chk("rst_err",      err, 0);
    chk("rst_im_we",    im_we, 0);
    chk("rst_im_addr",  im_addr, 0);
    chk("rst_im_wdata", im_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rx_ready", rx_ready, 1);
    $display("reset sequence complete");

    // Noise then nominal frame; checksum = 00^02^20^08^00^05^01^09^50^20 = 57
    wa.delete(); wd.delete();
    fr = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h02,
           8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    send_frame(0);
    chk("nom_done_before_csum",    done, 0);
    chk("nom_cpu_rst_before_csum", cpu_rst, 1);
    send_byte(8'h57);
    chk("nom_done",    done, 1);
    chk("nom_cpu_rst", cpu_rst, 0);
    chk("nom_err",     err, 0);
    expect_nominal_writes();
    chk_writes("nom");
    $display("frame nominal: writes=%0d done=%0d", wa.size(), done);

    // Restart after done, with random gaps inside the frame
    wa.delete(); wd.delete();
    send_byte(8'hA5);
    chk("restart_cpu_rst", cpu_rst, 1);
    chk("restart_done",    done, 0);
    fr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
           8'h01, 8'h09, 8'h50, 8'h20, 8'h57};
    send_frame(3);
    chk("gap_done",    done, 1);
    chk("gap_cpu_rst", cpu_rst, 0);
    expect_nominal_writes();
    chk_writes("gap");
    $display("frame restart+gaps: writes=%0d done=%0d", wa.size(), done);

    // Bad checksum
    wa.delete(); wd.delete();
    fr = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
           8'h01, 8'h09, 8'h50, 8'h20, 8'h7B};
    send_frame(0);
    chk("badcs_err",     err, 1);
    chk("badcs_done",    done, 0);
    chk("badcs_cpu_rst", cpu_rst, 1);
    expect_nominal_writes();
    chk_writes("badcs");
    $display("frame bad checksum: writes=%0d err=%0d", wa.size(), err);

    // Oversize length 0x0401 > 1024 words
    wa.delete(); wd.delete();
    send_byte(8'hA5);
    chk("over_err_cleared", err, 0);
    send_byte(8'h04);
    chk("over_err_before", err, 0);
    send_byte(8'h01);
    chk("over_err", err, 1);
    send_byte(8'h11);
    send_byte(8'h22);
    idle(2);
    chk("over_err_hold", err, 1);
    ea.delete(); ed.delete();
    chk_writes("over");
    $display("frame oversize: writes=%0d err=%0d", wa.size(), err);

    // Empty image
    wa.delete(); wd.delete();
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(0);
    chk("empty_done",    done, 1);
    chk("empty_cpu_rst", cpu_rst, 0);
    chk("empty_err",     err, 0);
    ea.delete(); ed.delete();
    chk_writes("empty");
    $display("frame empty: writes=%0d done=%0d", wa.size(), done);

    // Mid-frame reset after 5 data bytes
    wa.delete(); wd.delete();
    fr = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01};
    send_frame(0);
    ea = '{32'd0};
    ed = '{32'h20080005};
    chk_writes("mid_partial");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_done",     done, 0);
    chk("mid_rst_cpu_rst",  cpu_rst, 1);
    chk("mid_rst_rx_ready", rx_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_post_rx_ready", rx_ready, 1);
    wa.delete(); wd.delete();
    fr = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
           8'h01, 8'h09, 8'h50, 8'h20, 8'h57};
    send_frame(0);
    chk("mid_reload_done",    done, 1);
    chk("mid_reload_cpu_rst", cpu_rst, 0);
    expect_nominal_writes();
    chk_writes("mid_reload");
    $display("frame after mid-frame reset: writes=%0d done=%0d", wa.size(), done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
